// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with write-through WB bypass, load-use bubble
// insertion, flush/stall handling and a saturating bubble counter.
module id_ex_reg #(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_A1,
  input  logic [4:0]        id_A2,
  input  logic [31:0]       id_RD1,
  input  logic [31:0]       id_RD2,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rd,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_RFWr,
  input  logic [4:0]        wb_A3,
  input  logic [31:0]       wb_WD,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_A1,
  output logic [4:0]        ex_A2,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_RD1,
  output logic [31:0]       ex_RD2,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall,
  output logic              id_hold,
  output logic [31:0]       bubble_cnt
);

  logic [31:0] byp_rd1;
  logic [31:0] byp_rd2;

  // Register 0 is deliberately not excluded: the RF really stores writes to it.
  always_comb begin
    byp_rd1 = (wb_RFWr && (wb_A3 == id_A1)) ? wb_WD : id_RD1;
    byp_rd2 = (wb_RFWr && (wb_A3 == id_A2)) ? wb_WD : id_RD2;
  end

  assign hazard_stall = id_valid & ex_valid & ex_MemRead & ex_RegWrite &
                        (ex_rd != 5'd0) & ((ex_rd == id_A1) | (ex_rd == id_A2));
  assign id_hold      = ex_stall | hazard_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_A1       <= '0;
      ex_A2       <= '0;
      ex_rd       <= '0;
      ex_RD1      <= '0;
      ex_RD2      <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_ctrl     <= '0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_ctrl     <= '0;
    end else if (ex_stall) begin
      // Held operands must still track WB writes or they go stale.
      if (ex_valid && wb_RFWr && (wb_A3 == ex_A1)) ex_RD1 <= wb_WD;
      if (ex_valid && wb_RFWr && (wb_A3 == ex_A2)) ex_RD2 <= wb_WD;
    end else begin
      ex_pc  <= id_pc;
      ex_imm <= id_imm;
      ex_A1  <= id_A1;
      ex_A2  <= id_A2;
      ex_rd  <= id_rd;
      ex_RD1 <= byp_rd1;
      ex_RD2 <= byp_rd2;
      if (hazard_stall) begin
        ex_valid    <= 1'b0;
        ex_RegWrite <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_ctrl     <= '0;
        if (bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
      end else begin
        ex_valid    <= id_valid;
        ex_RegWrite <= id_valid & id_RegWrite;
        ex_MemRead  <= id_valid & id_MemRead;
        ex_ctrl     <= id_valid ? id_ctrl : '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed testbench for id_ex_reg: reset, bypass, load-use bubbles,
// stall hold-refresh and flush priority.
module tb_id_ex_reg;
  localparam int CTRL_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [31:0]       id_pc, id_RD1, id_RD2, id_imm;
  logic [4:0]        id_A1, id_A2, id_rd;
  logic              id_RegWrite, id_MemRead;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_RFWr;
  logic [4:0]        wb_A3;
  logic [31:0]       wb_WD;
  logic              flush, ex_stall;
  logic              ex_valid;
  logic [31:0]       ex_pc, ex_imm, ex_RD1, ex_RD2;
  logic [4:0]        ex_A1, ex_A2, ex_rd;
  logic              ex_RegWrite, ex_MemRead;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              hazard_stall, id_hold;
  logic [31:0]       bubble_cnt;

  int vectors = 0;
  int miscompares = 0;

  id_ex_reg #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_A1(id_A1),
    .id_A2(id_A2), .id_RD1(id_RD1), .id_RD2(id_RD2), .id_imm(id_imm),
    .id_rd(id_rd), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_ctrl(id_ctrl), .wb_RFWr(wb_RFWr), .wb_A3(wb_A3), .wb_WD(wb_WD),
    .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_A1(ex_A1), .ex_A2(ex_A2), .ex_rd(ex_rd),
    .ex_RD1(ex_RD1), .ex_RD2(ex_RD2), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall),
    .id_hold(id_hold), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_A1 = 0; id_A2 = 0; id_RD1 = 0; id_RD2 = 0;
    id_imm = 0; id_rd = 0; id_RegWrite = 0; id_MemRead = 0; id_ctrl = 0;
    wb_RFWr = 0; wb_A3 = 0; wb_WD = 0; flush = 0; ex_stall = 0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] rd1, input logic [31:0] rd2, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic [CTRL_W-1:0] ctrl);
    id_valid = 1; id_pc = pc; id_A1 = a1; id_A2 = a2; id_RD1 = rd1; id_RD2 = rd2;
    id_imm = pc + 32'h1000; id_rd = rd; id_RegWrite = rw; id_MemRead = mr; id_ctrl = ctrl;
  endtask

  initial begin
    idle();
    // reset with random inputs
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1; id_pc = $urandom; id_RD1 = $urandom; id_RD2 = $urandom;
      id_A1 = 5'($urandom); id_A2 = 5'($urandom); id_rd = 5'($urandom);
      id_RegWrite = 1; id_MemRead = 1; id_ctrl = 8'($urandom);
      wb_RFWr = 1; wb_A3 = id_A1; wb_WD = $urandom;
      tick();
    end
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_rd1", ex_RD1, 0);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_memread", ex_MemRead, 0);
    chk("rst_bcnt", bubble_cnt, 0);
    chk("rst_hazard", hazard_stall, 0);

    rst = 0; idle();
    set_instr(32'h40, 1, 2, 0, 0, 0, 0, 0, 0);
    tick();
    chk("first_valid", ex_valid, 1);
    chk("first_pc", ex_pc, 32'h40);

    // bypass hit / miss / register 0
    set_instr(32'h44, 5, 7, 32'h11, 32'h22, 1, 1, 0, 8'h01);
    wb_RFWr = 1; wb_A3 = 5; wb_WD = 32'hCAFE;
    tick();
    chk("byp_hit_rd1", ex_RD1, 32'hCAFE);
    chk("byp_hit_rd2", ex_RD2, 32'h22);
    wb_A3 = 6;
    tick();
    chk("byp_miss_rd1", ex_RD1, 32'h11);
    set_instr(32'h48, 0, 0, 32'h1, 32'h2, 1, 1, 0, 8'h01);
    wb_A3 = 0; wb_WD = 32'hBEEF;
    tick();
    chk("byp_r0_rd1", ex_RD1, 32'hBEEF);
    chk("byp_r0_rd2", ex_RD2, 32'hBEEF);
    wb_RFWr = 0;

    // load-use: load to x8, then consumer of x8 on A2
    set_instr(32'h80, 1, 2, 0, 0, 8, 1, 1, 8'h11);
    tick();
    set_instr(32'h100, 9, 8, 32'h99, 32'h88, 10, 1, 0, 8'h5A);
    #1;
    chk("lu_hazard", hazard_stall, 1);
    chk("lu_hold", id_hold, 1);
    tick();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_rw", ex_RegWrite, 0);
    chk("lu_bub_ctrl", ex_ctrl, 0);
    chk("lu_bcnt", bubble_cnt, 1);
    chk("lu_hazard_drop", hazard_stall, 0);
    tick();
    chk("lu_load_valid", ex_valid, 1);
    chk("lu_load_pc", ex_pc, 32'h100);
    chk("lu_load_ctrl", ex_ctrl, 8'h5A);

    // load to x0 never stalls
    set_instr(32'h120, 1, 2, 0, 0, 0, 1, 1, 8'h11);
    tick();
    set_instr(32'h124, 0, 0, 0, 0, 3, 1, 0, 8'h22);
    #1;
    chk("r0_no_hazard", hazard_stall, 0);
    tick();
    chk("r0_valid", ex_valid, 1);
    chk("r0_bcnt", bubble_cnt, 1);

    // stall with hold-refresh of RD1
    set_instr(32'h200, 3, 4, 32'h33, 32'h44, 5, 1, 0, 8'h0F);
    tick();
    set_instr(32'h300, 12, 13, 32'hAA, 32'hBB, 14, 1, 0, 8'hF0);
    ex_stall = 1;
    #1;
    chk("stall_hold", id_hold, 1);
    tick();
    chk("stall1_pc", ex_pc, 32'h200);
    chk("stall1_rd1", ex_RD1, 32'h33);
    wb_RFWr = 1; wb_A3 = 3; wb_WD = 32'h77;
    tick();
    chk("stall2_rd1", ex_RD1, 32'h77);
    chk("stall2_rd2", ex_RD2, 32'h44);
    wb_RFWr = 0;
    tick();
    chk("stall3_rd1", ex_RD1, 32'h77);
    chk("stall3_pc", ex_pc, 32'h200);
    chk("stall3_valid", ex_valid, 1);
    chk("stall3_ctrl", ex_ctrl, 8'h0F);
    chk("stall3_bcnt", bubble_cnt, 1);
    ex_stall = 0;

    // flush beats stall and hazard
    set_instr(32'h400, 1, 2, 0, 0, 8, 1, 1, 8'h3C);
    tick();
    set_instr(32'h500, 8, 2, 0, 0, 9, 1, 0, 8'h5A);
    flush = 1; ex_stall = 1;
    #1;
    chk("fl_hazard_pre", hazard_stall, 1);
    tick();
    chk("fl_valid", ex_valid, 0);
    chk("fl_rw", ex_RegWrite, 0);
    chk("fl_mr", ex_MemRead, 0);
    chk("fl_ctrl", ex_ctrl, 0);
    chk("fl_pc_hold", ex_pc, 32'h400);
    chk("fl_bcnt", bubble_cnt, 1);
    flush = 0; ex_stall = 0;

    // invalid ID slot forces control low
    set_instr(32'h600, 1, 2, 0, 0, 4, 1, 1, 8'hFF);
    id_valid = 0;
    tick();
    chk("inv_valid", ex_valid, 0);
    chk("inv_rw", ex_RegWrite, 0);
    chk("inv_ctrl", ex_ctrl, 0);

    // reset mid-run clears the counter
    rst = 1;
    tick();
    chk("rst2_bcnt", bubble_cnt, 0);
    chk("rst2_pc", ex_pc, 0);
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the register file.
- Captures RD1/RD2 plus decoded fields and presents them to the EX stage.
- The register file writes on the clock edge and reads combinationally, so a same-cycle WB write is not visible on RD1/RD2. This block applies write-through bypass of the WB write port to cover that gap.
- Also detects load-use hazards, inserts bubbles, honours flush and downstream stall, and counts inserted bubbles.

Parameters:
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle passed through unchanged.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID slot holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_A1  in  5  RF read address 1; the same value that drives RF A1.
- id_A2  in  5  RF read address 2; the same value that drives RF A2.
- id_RD1  in  32  RF read data 1.
- id_RD2  in  32  RF read data 2.
- id_imm  in  32  extended immediate.
- id_rd  in  5  destination register.
- id_RegWrite  in  1  instruction writes the RF.
- id_MemRead  in  1  instruction is a load.
- id_ctrl  in  CTRL_W  other control bits.
- wb_RFWr  in  1  WB write enable; the same signal that drives RF RFWr.
- wb_A3  in  5  WB write address.
- wb_WD  in  32  WB write data.
- flush  in  1  kill the instruction entering EX (branch/jump redirect).
- ex_stall  in  1  EX cannot accept; hold the register.
- ex_valid  out  1  registered valid.
- ex_pc, ex_imm  out  32  registered.
- ex_A1, ex_A2, ex_rd  out  5  registered.
- ex_RD1, ex_RD2  out  32  registered operands, bypassed.
- ex_RegWrite, ex_MemRead  out  1  registered.
- ex_ctrl  out  CTRL_W  registered.
- hazard_stall  out  1  combinational load-use stall request.
- id_hold  out  1  combinational: ex_stall | hazard_stall. Upstream holds PC and IF/ID when high.
- bubble_cnt  out  32  count of hazard bubbles inserted.

Behaviour:
- Reset (rst=1 at posedge): every registered output and bubble_cnt become 0. rst overrides all other inputs. There is no mid-operation recovery: the next cycle starts empty.
- hazard_stall = id_valid & ex_valid & ex_MemRead & ex_RegWrite & (ex_rd != 0) & (ex_rd == id_A1 | ex_rd == id_A2).
  - Both addresses are compared regardless of actual operand use. This is conservative by decision.
- Bypass, applied at every load: ex_RD1 <= (wb_RFWr & wb_A3 == id_A1) ? wb_WD : id_RD1; ex_RD2 likewise with id_A2.
  - Address 0 is not excluded, because the RF stores writes to register 0. The bypass must reproduce RF contents exactly.
- Posedge update priority, highest first:
  1. rst: as above.
  2. flush: ex_valid, ex_RegWrite, ex_MemRead and ex_ctrl go to 0; data fields hold. flush wins over ex_stall and hazard.
  3. ex_stall: all fields hold. Hold-refresh: if ex_valid & wb_RFWr & wb_A3 == ex_A1 then ex_RD1 <= wb_WD; likewise RD2 with ex_A2. bubble_cnt is not incremented.
  4. hazard_stall: insert a bubble. ex_valid and all control go to 0; data fields are don't-care (load them as in step 5). bubble_cnt increments, saturating at 32'hFFFFFFFF.
  5. Otherwise, load all id_* fields with bypass. If id_valid=0, ex_RegWrite, ex_MemRead and ex_ctrl are forced to 0.
- Latency: 1 cycle from ID to EX outputs.
- A load followed immediately by a dependent instruction costs exactly one bubble. On the following cycle ex_MemRead=0, so hazard_stall drops.
- Simultaneous flush and hazard: flush applies and no bubble is counted. hazard_stall may still be high combinationally; upstream ignores it during a redirect.
- Invariant: ex_valid=0 implies ex_RegWrite=ex_MemRead=0 and ex_ctrl=0.

Test Plan:
- Reset: drive random inputs with rst=1 for 2 cycles -> all outputs 0, bubble_cnt=0. Release with id_valid=1, id_pc=32'h40 -> next cycle ex_valid=1, ex_pc=32'h40.
- Bypass: id_A1=5, id_RD1=32'h11, wb_RFWr=1, wb_A3=5, wb_WD=32'hCAFE -> ex_RD1=32'hCAFE. Same with wb_A3=6 -> ex_RD1=32'h11. With id_A1=id_A2=0 and wb_A3=0 -> both ex_RD1 and ex_RD2 bypassed.
- Load-use: EX holds load (ex_MemRead=1, ex_RegWrite=1, ex_rd=8), id_A2=8, id_valid=1 -> hazard_stall=1, id_hold=1. Next cycle ex_valid=0, bubble_cnt=1. Following cycle the instruction loads and hazard_stall=0. Repeat with ex_rd=0 -> no stall.
- Stall hold-refresh: ex_valid=1, ex_A1=3, ex_stall=1 for 3 cycles; in cycle 2 wb_RFWr=1, wb_A3=3, wb_WD=32'h77 -> all fields stable except ex_RD1=32'h77; bubble_cnt unchanged.
- Flush priority: flush=1 together with ex_stall=1 and an active hazard -> ex_valid=0, all control 0, bubble_cnt unchanged.
- Saturation: force 2^32+3 hazard bubbles (or preload via reset-free run in formal/backdoor) -> bubble_cnt stays at 32'hFFFFFFFF.
